// File: rtl/button_hex_round.sv
// Front-panel helper: synchronised push-button press pulse, hex to 7-segment decode, pixel saturator.
// Optional BUTTON_DEBOUNCE_EN inserts a stable-count debouncer between the synchroniser and edge detect.
module button_hex_round #(
  parameter int PRECISION       = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        button,
  output logic                        pressed,
  input  logic [3:0]                  hex_bin,
  output logic [6:0]                  hex_seg,
  input  logic signed [PRECISION-1:0] round_in,
  output logic [7:0]                  round_out
);

  if (PRECISION < 9 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("button_hex_round: PRECISION must be >= 9 and DEBOUNCE_CYCLES >= 1");
  end

  logic s1_q, s2_q, prev_q, pressed_q;
  logic pressed_d;
  logic lvl;

  // Two-flop synchroniser; both flops idle at 1 (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= button;
      s2_q <= s1_q;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Debounced level follows s2 only after it has disagreed for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      db_d  = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign lvl = db_q;
`else
  assign lvl = s2_q;
`endif

  assign pressed_d = prev_q & ~lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 1'b1;
      pressed_q <= 1'b0;
    end else begin
      prev_q    <= lvl;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = 7'b1111111;
    case (hex_bin)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  end

  // Full-width signed compare so large values never alias into 0..255.
  localparam logic signed [PRECISION-1:0] SAT_MAX = PRECISION'(255);

  always_comb begin
    round_out = round_in[7:0];
    if (round_in < 0)
      round_out = 8'd0;
    else if (round_in > SAT_MAX)
      round_out = 8'd255;
  end

endmodule

// File: tb/tb_button_hex_round.sv
// Scoreboard bench for button_hex_round (default build): press pulses, hex decode, saturation.
module tb_button_hex_round;

  logic               clk = 1'b0;
  logic               reset;
  logic               button;
  logic               pressed;
  logic [3:0]         hex_bin;
  logic [6:0]         hex_seg;
  logic signed [15:0] round_in;
  logic [7:0]         round_out;

  int n_chk = 0;
  int n_err = 0;

  bit         press_q[$];
  logic [6:0] hex_q[$];
  logic [7:0] rnd_q[$];

  // Button history as seen by the bench: samples taken during reset count as released.
  bit eb1 = 1'b1, eb2 = 1'b1, eb3 = 1'b1, rst1 = 1'b1;

  always #5 clk = ~clk;

  button_hex_round #(.PRECISION(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .pressed  (pressed),
    .hex_bin  (hex_bin),
    .hex_seg  (hex_seg),
    .round_in (round_in),
    .round_out(round_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge with the given button/reset; expected pulse: low sampled two edges ago
  // after a released sample three edges ago, and no reset on this or the previous edge.
  task automatic step(input bit b, input bit r);
    bit exp;
    button = b;
    reset  = r;
    exp = !r && !rst1 && !eb2 && eb3;
    press_q.push_back(exp);
    eb3 = eb2; eb2 = eb1; eb1 = r ? 1'b1 : b; rst1 = r;
    @(posedge clk);
    #1;
    if (press_q.size() == 0) chk("press_q_empty", 1, 0);
    else chk("pressed", {31'd0, pressed}, {31'd0, press_q.pop_front()});
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [15:0] rin_tab [9] = '{16'hFFFF, 16'h0000, 16'd100, 16'd255, 16'd256,
                               16'h7FFF, 16'h8000, 16'hFF00, 16'd1};
  logic [7:0]  rout_tab[9] = '{8'd0, 8'd0, 8'd100, 8'd255, 8'd255,
                               8'd255, 8'd0, 8'd0, 8'd1};

  initial begin
    button   = 1'b1;
    reset    = 1'b1;
    hex_bin  = 4'h0;
    round_in = '0;
    @(negedge clk);

    // Reset state, then a 3-cycle press and release.
    step(1'b1, 1'b1);
    run(1'b1, 3);
    run(1'b0, 3);
    run(1'b1, 6);

    // Long hold: one pulse only.
    run(1'b0, 2000);
    run(1'b1, 6);

    // Two presses split by a single high sample.
    run(1'b0, 2);
    run(1'b1, 1);
    run(1'b0, 2);
    run(1'b1, 6);

    // Reset asserted mid-press, button kept low through release.
    run(1'b0, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(1'b0, 6);
    run(1'b1, 6);

    // Button low across reset deassert, then reset held with presses.
    step(1'b0, 1'b1);
    run(1'b0, 6);
    run(1'b1, 4);
    for (int i = 0; i < 6; i++) step(i[0], 1'b1);
    run(1'b1, 4);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    run(1'b1, 6);

    // Hex decoder sweep.
    for (int i = 0; i < 16; i++) begin
      hex_bin = 4'(i);
      hex_q.push_back(seg_tab[i]);
      #1;
      if (hex_q.size() == 0) chk("hex_q_empty", 1, 0);
      else chk($sformatf("hex_seg[%0h]", i), {25'd0, hex_seg}, {25'd0, hex_q.pop_front()});
    end

    // Saturator corners.
    for (int i = 0; i < 9; i++) begin
      round_in = rin_tab[i];
      rnd_q.push_back(rout_tab[i]);
      #1;
      if (rnd_q.size() == 0) chk("rnd_q_empty", 1, 0);
      else chk($sformatf("round_out[%0h]", rin_tab[i]), {24'd0, round_out}, {24'd0, rnd_q.pop_front()});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
